// File: rtl/mi_pkg.sv
// Shared definitions for the mi_* burst memory interface: state encoding and bus widths.
package mi_pkg;
    localparam int MI_DW     = 16;
    localparam int MI_LW     = 7;
    localparam int MI_AW_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mi_state_e;
endpackage

// File: rtl/mi_ram_responder.sv
// mi_* responder over a 1-cycle-latency single-port RAM: one word per cycle, read data at accept+2.
// Commands stall via mi_ready outside IDLE; read data and write pulls are never backpressured.
module mi_ram_responder
    import mi_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = MI_DW,
    parameter int LW = MI_LW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MI_AW_MAX-1:0] mi_addr,
    input  logic [LW-1:0]        mi_len,
    input  logic                 mi_rw,
    input  logic                 mi_valid,
    output logic                 mi_ready,
    input  logic [DW-1:0]        mi_wdata,
    output logic                 mi_wack,
    output logic                 mi_wlast,
    output logic [DW-1:0]        mi_rdata,
    output logic                 mi_rstb,
    output logic                 mi_rlast,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [DW-1:0]        ram_rdata,
    output logic                 busy
);

    mi_state_e     state_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] cnt_q;
    logic          rstb_q;
    logic          rlast_q;

    logic          last_word;
    logic [AW-1:0] addr_d;
    logic [LW-1:0] cnt_d;
    logic          unused_addr_hi;

    // The RAM only decodes AW bits; the rest of the initiator address is don't-care.
    assign unused_addr_hi = ^mi_addr[MI_AW_MAX-1:AW];

    assign last_word = (cnt_q == '0);
    assign addr_d    = addr_q + AW'(1);
    assign cnt_d     = cnt_q - LW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rstb_q  <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            // Read data comes back one cycle after issue, so strobe and last trail the issue by one.
            rstb_q  <= (state_q == ST_RD);
            rlast_q <= (state_q == ST_RD) && last_word;
            case (state_q)
                ST_IDLE: begin
                    if (mi_valid) begin
                        addr_q  <= mi_addr[AW-1:0];
                        cnt_q   <= mi_len;
                        state_q <= mi_rw ? ST_RD : ST_WR;
                    end
                end
                ST_RD, ST_WR: begin
                    addr_q <= addr_d;
                    cnt_q  <= cnt_d;
                    if (last_word) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mi_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    assign ram_addr  = addr_q;
    assign ram_wdata = mi_wdata;
    assign ram_re    = (state_q == ST_RD);
    assign ram_we    = (state_q == ST_WR);

    assign mi_wack   = (state_q == ST_WR);
    assign mi_wlast  = (state_q == ST_WR) && last_word;

    assign mi_rdata  = ram_rdata;
    assign mi_rstb   = rstb_q;
    assign mi_rlast  = rlast_q;

endmodule

// File: tb/tb_mi_ram_responder.sv
// Bench for mi_ram_responder: table of bursts against a behavioural RAM with a read scoreboard.
module tb_mi_ram_responder;
    import mi_pkg::*;

    localparam int AW = 14;
    localparam int DW = MI_DW;
    localparam int LW = MI_LW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [MI_AW_MAX-1:0] mi_addr = '0;
    logic [LW-1:0]        mi_len = '0;
    logic                 mi_rw = 1'b0;
    logic                 mi_valid = 1'b0;
    logic                 mi_ready;
    logic [DW-1:0]        mi_wdata = '0;
    logic                 mi_wack;
    logic                 mi_wlast;
    logic [DW-1:0]        mi_rdata;
    logic                 mi_rstb;
    logic                 mi_rlast;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic                 ram_we;
    logic                 ram_re;
    logic [DW-1:0]        ram_rdata;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;
    int rd_seen = 0;
    logic [DW-1:0] first_word = '0;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          first;
    } rexp_t;

    typedef struct {
        logic          rw;
        logic [31:0]   addr;
        logic [LW-1:0] len;
        logic [DW-1:0] seed;
        logic [DW-1:0] step;
        logic [DW-1:0] exp_first;
    } vec_t;

    rexp_t         rd_q[$];
    logic [AW-1:0] ra_q[$];
    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] model [0:(1<<AW)-1];

    mi_ram_responder #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
        .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
        .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read data one cycle after ram_re.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;
        mem[16'h0010] = 16'hBEEF;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] = ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event, required none", nm);
    endtask

    always @(negedge clk) begin
        rexp_t e;
        if (rst_n) begin
            chk("re_we_exclusive", 32'(ram_re & ram_we), 32'd0);
            if (ram_re) begin
                if (ra_q.size() == 0) note_fail("stray_ram_re");
                else chk("ram_raddr", 32'(ram_addr), 32'(ra_q.pop_front()));
            end
            if (mi_rstb) begin
                if (rd_q.size() == 0) begin
                    note_fail("stray_rstb");
                end else begin
                    e = rd_q.pop_front();
                    chk("rdata", 32'(mi_rdata), 32'(e.d));
                    chk("rlast", 32'(mi_rlast), 32'(e.last));
                    if (e.first) first_word = mi_rdata;
                end
                rd_seen++;
            end else if (mi_rlast) begin
                note_fail("rlast_without_rstb");
            end
            if (mi_rlast) chk("ready_at_rlast", 32'(mi_ready), 32'd1);
        end
    end

    task automatic issue(input logic rw, input logic [31:0] a, input logic [LW-1:0] l,
                         input logic [DW-1:0] wd0);
        logic [AW-1:0] ra;
        int n;
        mi_rw = rw; mi_addr = a; mi_len = l; mi_wdata = wd0; mi_valid = 1'b1;
        if (rw) begin
            ra = a[AW-1:0];
            for (int k = 0; k <= int'(l); k++) begin
                rd_q.push_back('{d: model[ra], last: (k == int'(l)), first: (k == 0)});
                ra_q.push_back(ra);
                ra = ra + AW'(1);
            end
        end
        n = 0;
        while (!mi_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mi_ready) note_fail("cmd_accept_timeout");
        @(posedge clk);
        #1;
        // Command fields only need to hold in the accept cycle.
        mi_valid = 1'b0;
        mi_rw    = 1'($urandom);
        mi_addr  = $urandom;
        mi_len   = LW'($urandom);
    endtask

    task automatic wait_read(input logic [LW-1:0] l);
        for (int k = 0; k <= int'(l); k++) begin
            @(negedge clk);
            chk("rd_ready_low", 32'(mi_ready), 32'd0);
            chk("rd_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("rd_ready_back", 32'(mi_ready), 32'd1);
        #1;
        chk("rd_sb_drained", 32'(rd_q.size()), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [LW-1:0] l,
                            input logic [DW-1:0] seed, input logic [DW-1:0] step);
        logic [AW-1:0] wa;
        logic [DW-1:0] w;
        issue(1'b0, a, l, seed);
        // A read command offered mid-burst must be ignored.
        mi_valid = 1'b1; mi_rw = 1'b1; mi_len = '0; mi_addr = '0;
        wa = a[AW-1:0];
        w  = seed;
        for (int k = 0; k <= int'(l); k++) begin
            @(negedge clk);
            chk("wack", 32'(mi_wack), 32'd1);
            chk("wlast", 32'(mi_wlast), 32'(k == int'(l)));
            chk("wr_ram_we", 32'(ram_we), 32'd1);
            chk("wr_ram_addr", 32'(ram_addr), 32'(wa));
            chk("wr_ram_wdata", 32'(ram_wdata), 32'(w));
            chk("wr_ready_low", 32'(mi_ready), 32'd0);
            model[wa] = w;
            wa = wa + AW'(1);
            w  = w + step;
            @(posedge clk);
            #1;
            mi_wdata = w;
            if (k == int'(l)) mi_valid = 1'b0;
        end
        @(negedge clk);
        chk("wr_ready_back", 32'(mi_ready), 32'd1);
        chk("wr_wack_off", 32'(mi_wack), 32'd0);
        chk("wr_we_off", 32'(ram_we), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int base;
        int n;

        vecs[0] = '{rw: 1'b1, addr: 32'h0000_0010, len: 7'd0,   seed: 16'h0,    step: 16'h0,    exp_first: 16'hBEEF};
        vecs[1] = '{rw: 1'b1, addr: 32'h0000_0040, len: 7'd63,  seed: 16'h0,    step: 16'h0,    exp_first: 16'h5A1A};
        vecs[2] = '{rw: 1'b0, addr: 32'h0000_3FFE, len: 7'd3,   seed: 16'h1111, step: 16'h1111, exp_first: 16'h0};
        vecs[3] = '{rw: 1'b1, addr: 32'h0000_3FFE, len: 7'd3,   seed: 16'h0,    step: 16'h0,    exp_first: 16'h1111};
        vecs[4] = '{rw: 1'b1, addr: 32'hFFFF_C005, len: 7'd0,   seed: 16'h0,    step: 16'h0,    exp_first: 16'h5A5F};
        vecs[5] = '{rw: 1'b0, addr: 32'h0000_2000, len: 7'd127, seed: 16'h0101, step: 16'h0203, exp_first: 16'h0};
        vecs[6] = '{rw: 1'b1, addr: 32'h0000_2000, len: 7'd127, seed: 16'h0,    step: 16'h0,    exp_first: 16'h0101};

        for (int i = 0; i < (1 << AW); i++) model[i] = DW'(i) ^ 16'h5A5A;
        model[16'h0010] = 16'hBEEF;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(mi_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rstb", 32'(mi_rstb), 32'd0);
        chk("rst_rlast", 32'(mi_rlast), 32'd0);
        chk("rst_wack", 32'(mi_wack), 32'd0);
        chk("rst_wlast", 32'(mi_wlast), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_re", 32'(ram_re), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(mi_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rw) begin
                issue(1'b1, vecs[i].addr, vecs[i].len, '0);
                wait_read(vecs[i].len);
                chk("first_word", 32'(first_word), 32'(vecs[i].exp_first));
            end else begin
                do_write(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].step);
            end
        end

        // Write then read issued in the very cycle ready returns.
        do_write(32'h0000_0100, 7'd1, 16'hAAAA, 16'hAAAB);
        issue(1'b1, 32'h0000_0100, 7'd1, '0);
        wait_read(7'd1);
        chk("b2b_first", 32'(first_word), 32'h0000_AAAA);

        // Reset in the middle of a long read.
        base = rd_seen;
        issue(1'b1, 32'h0000_0000, 7'd63, '0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((rd_seen - base) < 10 && n < 100);
        chk("abort_tenth_rstb", 32'(mi_rstb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rstb", 32'(mi_rstb), 32'd0);
        chk("abort_rlast", 32'(mi_rlast), 32'd0);
        chk("abort_ram_re", 32'(ram_re), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(mi_ready), 32'd1);
        rd_q.delete();
        ra_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("after_abort_busy", 32'(busy), 32'd0);
            chk("after_abort_ready", 32'(mi_ready), 32'd1);
        end

        issue(1'b1, 32'h0000_0010, 7'd1, '0);
        wait_read(7'd1);
        chk("post_abort_first", 32'(first_word), 32'h0000_BEEF);

        chk("sb_empty", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
